// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//     - state_t       : FSM encoding (IDLE=0, SHIFT=1)
//     - WIDTH_MIN/MAX : legal operand width range
//     - clog2_min1()  : counter sizing, never narrower than one bit
package serial_adder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    // ceil(log2(v)), clamped to 1 so a WIDTH=1 adder still gets a real counter bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// serial_adder_fulladder
//   Single-bit full adder cell.
//   Ports:
//     a, b, ci : addend bits and carry-in
//     s        : sum bit
//     co       : carry-out
module serial_adder_fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are captured on an accepted start,
//   then one bit per clock (LSB first) goes through the full adder cell with
//   the carry held in a flop. {cout,sum} = a + b + cin, valid with the
//   one-cycle done pulse after WIDTH shift edges.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     start         : request an add (only sampled while idle)
//     a, b, cin     : operands and carry-in, captured on the start edge
//     busy          : add in progress
//     done          : one-cycle completion pulse
//     sum, cout     : registered result, held until the next completion
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = clog2_min1(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, psum, psum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;
    logic             load, step, last;

    serial_adder_fulladder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Partial sum shifts right; the new bit enters at the MSB so that after
    // WIDTH steps the LSB-first stream lands in natural bit order.
    always_comb begin
        psum_nxt            = psum >> 1;
        psum_nxt[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    assign busy = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (step) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            psum  <= psum_nxt;
            carry <= fa_co;
            cnt   <= cnt + CW'(1);
        end
    end

    // Result registers only move on completion, so a new add started in the
    // done cycle leaves the previous result visible until it finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (last) begin
                sum  <= psum_nxt;
                cout <= fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one 8-bit add from a negedge and wait for done; returns the number
    // of edges after the start edge and the number of busy cycles seen.
    task automatic go8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       output int lat, output int nbusy);
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0; nbusy = 0;
        while (!done8 && lat < 20) begin
            if (busy8) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, nb, extra, gap;

        // reset state
        #12;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum",  sum8,  0);
        chk("rst_cout", cout8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic add: 0x5A + 0x33 = 0x08D
        go8(8'h5A, 8'h33, 1'b0, lat, nb);
        chk("basic_lat",  lat, 8);
        chk("basic_busy", nb, 8);
        chk("basic_sum",  sum8, 8'h8D);
        chk("basic_cout", cout8, 0);
        chk("basic_bsy0", busy8, 0);
        @(negedge clk);
        chk("done_pulse", done8, 0);
        chk("sum_hold",   sum8, 8'h8D);

        // carry ripple
        go8(8'hFF, 8'h01, 1'b0, lat, nb);
        chk("rip1_sum",  sum8, 8'h00);
        chk("rip1_cout", cout8, 1);
        go8(8'hFF, 8'hFF, 1'b1, lat, nb);
        chk("rip2_sum",  sum8, 8'hFF);
        chk("rip2_cout", cout8, 1);
        go8(8'h00, 8'h00, 1'b1, lat, nb);
        chk("cin_sum",   sum8, 8'h01);
        chk("cin_cout",  cout8, 0);

        // start while busy is dropped
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            if (lat == 3) begin
                a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start8 = 1'b0;
        chk("bsy_lat",  lat, 8);
        chk("bsy_sum",  sum8, 8'h02);
        chk("bsy_cout", cout8, 0);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) extra++;
        end
        chk("bsy_nodone", extra, 0);
        chk("bsy_idle",   busy8, 0);

        // back-to-back: new start in the done cycle
        go8(8'h01, 8'h01, 1'b0, lat, nb);
        chk("b2b_first", sum8, 8'h02);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        gap = 1;
        while (!done8 && gap < 20) begin
            if (gap == 4) chk("b2b_hold", sum8, 8'h02);
            @(negedge clk);
            gap++;
        end
        chk("b2b_gap",  gap, 9);
        chk("b2b_sum",  sum8, 8'h30);
        chk("b2b_cout", cout8, 0);

        // reset mid-operation
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", busy8, 0);
        chk("mid_sum",  sum8,  0);
        chk("mid_cout", cout8, 0);
        chk("mid_done", done8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        chk("mid_quiet", extra, 0);
        go8(8'hAA, 8'h55, 1'b0, lat, nb);
        chk("post_lat",  lat, 8);
        chk("post_sum",  sum8, 8'hFF);
        chk("post_cout", cout8, 0);

        // WIDTH=1 corner
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("w1_busy", busy1, 1);
        lat = 0;
        while (!done1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("w1_lat",  lat, 1);
        chk("w1_sum",  sum1, 1);
        chk("w1_cout", cout1, 1);
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        chk("w1b_done", done1, 1);
        chk("w1b_sum",  sum1, 1);
        chk("w1b_cout", cout1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial WIDTH-bit adder built around the existing single-bit full adder cell. It consumes the cell's sum and carry outputs one bit per clock, LSB first, and holds the carry in a flop between bits. A start/busy/done handshake fronts it. This is the area-cheap alternative to a ripple-carry array for datapaths that can tolerate WIDTH+1 cycles of latency.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an add; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepted-start edge.
- b  input  WIDTH  operand B; captured on the accepted-start edge.
- cin  input  1  carry-in; captured on the accepted-start edge.
- busy  output  1  high while an add is in progress.
- done  output  1  one-cycle pulse when sum and cout become valid.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered final carry; held with sum.

Behaviour:
Reset:
- rst_n low forces, asynchronously, state=IDLE, busy=0, done=0, sum=0, cout=0, and clears the shift registers, carry flop and bit counter.

States:
- IDLE:
  - busy=0.
  - On an edge with start=1: load shift regs A<=a, B<=b, carry<=cin, count<=0, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - busy=1.
  - The full adder inputs are A[0], B[0] and carry.
  - Each edge: partial sum reg shifts right with the cell's sum output entering at the MSB; carry<=cell carry output; A and B shift right with zero fill; count<=count+1.
  - On the edge where count==WIDTH-1, the bit is processed as above and additionally:
    - sum<=final partial sum (including this bit);
    - cout<=final carry;
    - done<=1;
    - state returns to IDLE.

Done and timing:
- done is high for exactly the one cycle after that edge; it is cleared on the next edge.
- Latency: start sampled at edge 0; WIDTH shift edges follow (edges 1..WIDTH); done and valid sum/cout are visible after edge WIDTH.
- Throughput: one add per WIDTH+1 cycles.

Arithmetic:
- {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1).
- No overflow flag; the signed interpretation is left to the consumer.

Boundary conditions:
- start while busy=1: ignored. Operands are not re-sampled and no extra done is produced.
- start in the same cycle done=1: accepted, because state is already IDLE. The new add proceeds normally; sum/cout keep the just-completed result until the new completion.
- a, b, cin changing during SHIFT: no effect.
- rst_n asserted mid-operation: aborts immediately, no done pulse, outputs return to reset values. After release, the block idles until a fresh start.
- WIDTH=1: a single SHIFT cycle; done follows one edge after the start edge.
- count width is clog2(WIDTH), minimum 1 bit. count must not wrap before the exit compare.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=1'b0, SHIFT=1'b1;
  - the WIDTH range limits;
  - a clog2 helper function for sizing the counter.
- One sub-module: instantiate the existing fulladder cell. Its sum output drives the serial sum bit; its carry output drives the carry flop input.
- No other hierarchy. The FSM, counter and shift registers stay in serial_adder.

Test Plan:
- Basic add: WIDTH=8, a=0x5A, b=0x33, cin=0, start pulse -> busy high 8 cycles; done after edge 8; sum=0x8D, cout=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start during busy: start a=0x01, b=0x01; re-assert start with a=0x80, b=0x80 at cycle 3 -> a single done with sum=0x02, cout=0; second request dropped.
- Back-to-back: new start (a=0x10, b=0x20) in the done cycle -> accepted; sum holds the previous value until the second done, then sum=0x30; exactly 9 cycles between done pulses.
- Reset mid-op: start a=0xAA, b=0x55; drop rst_n at cycle 4 -> busy=0, sum=0, cout=0 immediately; no done; a subsequent start runs to the correct result.
- Parameter corner: WIDTH=1, a=1, b=1, cin=1 -> done after edge 1; sum=1, cout=1.
